// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor
// Direction predictor built from a register table of saturating counters.
// Fetch issues lookups; the branch-resolve stage writes outcomes back using
// the index returned with the prediction. MODE=1 hashes the lookup address
// with the global history register (gshare), MODE=0 uses the address alone.
// A same-cycle update to the entry being looked up is forwarded (write-first).
module gshare_branch_predictor #(
    parameter int INDEX_BITS = 5,
    parameter int CTR_BITS   = 2,
    parameter int GHR_BITS   = 5,
    parameter int MODE       = 1,
    parameter int STAT_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  lookup_en,
    input  logic [INDEX_BITS-1:0] lookup_addr,
    output logic                  pred_valid,
    output logic                  pred_taken,
    output logic [INDEX_BITS-1:0] pred_index,
    input  logic                  upd_en,
    input  logic [INDEX_BITS-1:0] upd_index,
    input  logic                  upd_taken,
    input  logic                  upd_pred,
    output logic [GHR_BITS-1:0]   ghr,
    output logic [STAT_BITS-1:0]  stat_lookups,
    output logic [STAT_BITS-1:0]  stat_mispredict
);

    localparam int ENTRIES = 2 ** INDEX_BITS;

    localparam logic [CTR_BITS-1:0]  CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0]  CTR_MIN  = {CTR_BITS{1'b0}};
    localparam logic [CTR_BITS-1:0]  CTR_ONE  = CTR_BITS'(1'b1);
    // All ones shifted right once is 2^(CTR_BITS-1)-1: weakly not-taken.
    localparam logic [CTR_BITS-1:0]  CTR_INIT = CTR_MAX >> 1'b1;
    localparam logic [STAT_BITS-1:0] STAT_MAX = {STAT_BITS{1'b1}};
    localparam logic [STAT_BITS-1:0] STAT_ONE = STAT_BITS'(1'b1);

    // Saturating up/down step of one direction counter.
    function automatic logic [CTR_BITS-1:0] ctr_step(
        input logic [CTR_BITS-1:0] ctr,
        input logic                taken
    );
        logic [CTR_BITS-1:0] res;
        if (taken) begin
            if (ctr == CTR_MAX) res = ctr;
            else                res = ctr + CTR_ONE;
        end else begin
            if (ctr == CTR_MIN) res = ctr;
            else                res = ctr - CTR_ONE;
        end
        return res;
    endfunction

    // Statistics counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_BITS-1:0] stat_inc(
        input logic [STAT_BITS-1:0] cnt,
        input logic                 inc
    );
        logic [STAT_BITS-1:0] res;
        if (inc && (cnt != STAT_MAX)) res = cnt + STAT_ONE;
        else                          res = cnt;
        return res;
    endfunction

    logic [CTR_BITS-1:0]   table_r [ENTRIES];
    logic [GHR_BITS-1:0]   ghr_r;
    logic                  pred_valid_r;
    logic                  pred_taken_r;
    logic [INDEX_BITS-1:0] pred_index_r;
    logic [STAT_BITS-1:0]  stat_lookups_r;
    logic [STAT_BITS-1:0]  stat_mispredict_r;

    logic [INDEX_BITS-1:0] ghr_ext_s;
    logic [INDEX_BITS-1:0] lookup_idx_s;
    logic [CTR_BITS-1:0]   upd_ctr_s;
    logic [CTR_BITS-1:0]   lookup_ctr_s;
    logic [GHR_BITS-1:0]   ghr_next_s;
    logic                  mispredict_s;

    // Lookup index: raw address, or address hashed with the pre-update history.
    always_comb begin
        ghr_ext_s                 = {INDEX_BITS{1'b0}};
        ghr_ext_s[GHR_BITS-1:0]   = ghr_r;
        if (MODE != 32'd0) begin
            lookup_idx_s = lookup_addr ^ ghr_ext_s;
        end else begin
            lookup_idx_s = lookup_addr;
        end
    end

    // New counter value for the updated entry, forwarded to a matching lookup.
    always_comb begin
        upd_ctr_s = ctr_step(table_r[upd_index], upd_taken);
        if (upd_en && (upd_index == lookup_idx_s)) begin
            lookup_ctr_s = upd_ctr_s;
        end else begin
            lookup_ctr_s = table_r[lookup_idx_s];
        end
    end

    // Next history shifts the resolved outcome in at the LSB; works for GHR_BITS=1 too.
    always_comb begin
        ghr_next_s    = ghr_r << 1'b1;
        ghr_next_s[0] = upd_taken;
        mispredict_s  = upd_en && (upd_taken != upd_pred);
    end

    // Counter table: reset to weakly not-taken, otherwise write only the updated entry.
    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_r[i] <= CTR_INIT;
            end
        end else if (upd_en) begin
            table_r[upd_index] <= upd_ctr_s;
        end else begin
            table_r[upd_index] <= table_r[upd_index];
        end
    end

    // Global history register, advanced on every resolved update.
    always_ff @(posedge clk) begin
        if (srst) begin
            ghr_r <= {GHR_BITS{1'b0}};
        end else if (upd_en) begin
            ghr_r <= ghr_next_s;
        end else begin
            ghr_r <= ghr_r;
        end
    end

    // Registered prediction; direction and index hold when no lookup is issued.
    always_ff @(posedge clk) begin
        if (srst) begin
            pred_valid_r <= 1'b0;
            pred_taken_r <= 1'b0;
            pred_index_r <= {INDEX_BITS{1'b0}};
        end else if (lookup_en) begin
            pred_valid_r <= 1'b1;
            pred_taken_r <= lookup_ctr_s[CTR_BITS-1];
            pred_index_r <= lookup_idx_s;
        end else begin
            pred_valid_r <= 1'b0;
            pred_taken_r <= pred_taken_r;
            pred_index_r <= pred_index_r;
        end
    end

    // Saturating lookup and mispredict statistics.
    always_ff @(posedge clk) begin
        if (srst) begin
            stat_lookups_r    <= {STAT_BITS{1'b0}};
            stat_mispredict_r <= {STAT_BITS{1'b0}};
        end else begin
            stat_lookups_r    <= stat_inc(stat_lookups_r, lookup_en);
            stat_mispredict_r <= stat_inc(stat_mispredict_r, mispredict_s);
        end
    end

    assign pred_valid      = pred_valid_r;
    assign pred_taken      = pred_taken_r;
    assign pred_index      = pred_index_r;
    assign ghr             = ghr_r;
    assign stat_lookups    = stat_lookups_r;
    assign stat_mispredict = stat_mispredict_r;

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Testbench for gshare_branch_predictor. Two instances share the stimulus:
// dut_a uses the default gshare configuration, dut_b is bimodal with 4-bit
// statistics so saturation is reachable quickly. Expected values come from a
// small arithmetic model of the predictor (integer counters clamped to range).
module tb_gshare_branch_predictor;

    logic       clk = 1'b0;
    logic       srst;
    logic       lookup_en;
    logic [4:0] lookup_addr;
    logic       upd_en;
    logic [4:0] upd_index;
    logic       upd_taken;
    logic       upd_pred;

    logic        a_valid, a_taken;
    logic [4:0]  a_index, a_ghr;
    logic [15:0] a_sl, a_sm;
    logic        b_valid, b_taken;
    logic [4:0]  b_index, b_ghr;
    logic [3:0]  b_sl, b_sm;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int ctr_a [32];
    int ctr_b [32];
    int m_ghr;
    int sl_a, sm_a, sl_b, sm_b;
    int ev, eta, etb, eia, eib;

    always #5 clk = ~clk;

    gshare_branch_predictor #(.INDEX_BITS(5), .CTR_BITS(2), .GHR_BITS(5), .MODE(1), .STAT_BITS(16)) dut_a (
        .clk(clk), .srst(srst), .lookup_en(lookup_en), .lookup_addr(lookup_addr),
        .pred_valid(a_valid), .pred_taken(a_taken), .pred_index(a_index),
        .upd_en(upd_en), .upd_index(upd_index), .upd_taken(upd_taken), .upd_pred(upd_pred),
        .ghr(a_ghr), .stat_lookups(a_sl), .stat_mispredict(a_sm)
    );

    gshare_branch_predictor #(.INDEX_BITS(5), .CTR_BITS(2), .GHR_BITS(5), .MODE(0), .STAT_BITS(4)) dut_b (
        .clk(clk), .srst(srst), .lookup_en(lookup_en), .lookup_addr(lookup_addr),
        .pred_valid(b_valid), .pred_taken(b_taken), .pred_index(b_index),
        .upd_en(upd_en), .upd_index(upd_index), .upd_taken(upd_taken), .upd_pred(upd_pred),
        .ghr(b_ghr), .stat_lookups(b_sl), .stat_mispredict(b_sm)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare both instances.
    task automatic step(input logic rs, input logic le, input int la,
                        input logic ue, input int ui, input logic ut, input logic up);
        int ia;
        @(negedge clk);
        srst = rs; lookup_en = le; lookup_addr = 5'(la);
        upd_en = ue; upd_index = 5'(ui); upd_taken = ut; upd_pred = up;
        if (rs) begin
            for (int i = 0; i < 32; i++) begin
                ctr_a[i] = 1;
                ctr_b[i] = 1;
            end
            m_ghr = 0; sl_a = 0; sm_a = 0; sl_b = 0; sm_b = 0;
            ev = 0; eta = 0; etb = 0; eia = 0; eib = 0;
        end else begin
            ia = la ^ m_ghr;
            if (ue) begin
                ctr_a[ui] = ut ? ((ctr_a[ui] + 1 > 3) ? 3 : ctr_a[ui] + 1)
                               : ((ctr_a[ui] - 1 < 0) ? 0 : ctr_a[ui] - 1);
                ctr_b[ui] = ut ? ((ctr_b[ui] + 1 > 3) ? 3 : ctr_b[ui] + 1)
                               : ((ctr_b[ui] - 1 < 0) ? 0 : ctr_b[ui] - 1);
                m_ghr = ((m_ghr * 2) + (ut ? 1 : 0)) % 32;
                if (ut != up) begin
                    sm_a = (sm_a + 1 > 65535) ? 65535 : sm_a + 1;
                    sm_b = (sm_b + 1 > 15) ? 15 : sm_b + 1;
                end
            end
            if (le) begin
                ev  = 1;
                eia = ia;
                eib = la;
                eta = (ctr_a[ia] >= 2) ? 1 : 0;
                etb = (ctr_b[la] >= 2) ? 1 : 0;
                sl_a = (sl_a + 1 > 65535) ? 65535 : sl_a + 1;
                sl_b = (sl_b + 1 > 15) ? 15 : sl_b + 1;
            end else begin
                ev = 0;
            end
        end
        @(posedge clk);
        #1;
        check("a_valid", 32'(a_valid), 32'(ev));
        check("a_taken", 32'(a_taken), 32'(eta));
        check("a_index", 32'(a_index), 32'(eia));
        check("a_ghr",   32'(a_ghr),   32'(m_ghr));
        check("a_stat_lookups",    32'(a_sl), 32'(sl_a));
        check("a_stat_mispredict", 32'(a_sm), 32'(sm_a));
        check("b_valid", 32'(b_valid), 32'(ev));
        check("b_taken", 32'(b_taken), 32'(etb));
        check("b_index", 32'(b_index), 32'(eib));
        check("b_ghr",   32'(b_ghr),   32'(m_ghr));
        check("b_stat_lookups",    32'(b_sl), 32'(sl_b));
        check("b_stat_mispredict", 32'(b_sm), 32'(sm_b));
    endtask

    initial begin
        int la, ui;
        srst = 1'b1; lookup_en = 1'b0; lookup_addr = 5'd0;
        upd_en = 1'b0; upd_index = 5'd0; upd_taken = 1'b0; upd_pred = 1'b0;

        // 1: reset, then lookup 3
        step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3, 1'b0, 0, 1'b0, 1'b0);
        check("t1_valid", 32'(a_valid), 32'd1);
        check("t1_taken", 32'(a_taken), 32'd0);
        check("t1_index", 32'(a_index), 32'd3);
        check("t1_ghr",   32'(a_ghr),   32'd0);

        // 2: bimodal saturation on entry 7
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 0, 1'b1, 7, 1'b1, 1'b1);
        step(1'b0, 1'b1, 7, 1'b0, 0, 1'b0, 1'b0);
        check("t2_sat_taken", 32'(b_taken), 32'd1);
        step(1'b0, 1'b0, 0, 1'b1, 7, 1'b0, 1'b1);
        step(1'b0, 1'b1, 7, 1'b0, 0, 1'b0, 1'b0);
        check("t2_weak_taken", 32'(b_taken), 32'd1);
        step(1'b0, 1'b0, 0, 1'b1, 7, 1'b0, 1'b1);
        step(1'b0, 1'b1, 7, 1'b0, 0, 1'b0, 1'b0);
        check("t2_weak_not", 32'(b_taken), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b1, 7, 1'b0, 1'b0);
        step(1'b0, 1'b1, 7, 1'b0, 0, 1'b0, 1'b0);
        check("t2_floor", 32'(b_taken), 32'd0);

        // 3: write-first bypass on entry 4
        step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4, 1'b1, 4, 1'b1, 1'b0);
        check("t3_bypass_a", 32'(a_taken), 32'd1);
        check("t3_bypass_b", 32'(b_taken), 32'd1);

        // 4: history taken,not,taken then hashed lookup
        step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b1, 9, 1'b1, 1'b1);
        step(1'b0, 1'b0, 0, 1'b1, 9, 1'b0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b1, 9, 1'b1, 1'b1);
        check("t4_ghr", 32'(a_ghr), 32'h05);
        step(1'b0, 1'b1, 7, 1'b0, 0, 1'b0, 1'b0);
        check("t4_index", 32'(a_index), 32'h02);

        // 5: statistics saturation on the 4-bit instance
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, i, 1'b0, 0, 1'b0, 1'b0);
        check("t5_lookups_sat", 32'(b_sl), 32'd15);
        step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b1, 1, 1'b0, 1'b1);
        check("t5_mispredict", 32'(b_sm), 32'd3);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 0, 1'b1, 1, 1'b0, 1'b1);
        check("t5_mispredict_sat", 32'(b_sm), 32'd15);

        // 6: reset dominates a same-cycle lookup and update
        step(1'b0, 1'b1, 2, 1'b1, 2, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2, 1'b1, 2, 1'b1, 1'b0);
        check("t6_valid", 32'(a_valid), 32'd0);
        check("t6_ghr",   32'(a_ghr),   32'd0);
        check("t6_stats", 32'(a_sl),    32'd0);
        step(1'b0, 1'b1, 2, 1'b0, 0, 1'b0, 1'b0);
        check("t6_taken", 32'(b_taken), 32'd0);

        // random traffic, biased toward same-entry update/lookup collisions
        for (int n = 0; n < 400; n++) begin
            la = int'($urandom_range(0, 31));
            case ($urandom_range(0, 2))
                0:       ui = la ^ m_ghr;
                1:       ui = la;
                default: ui = int'($urandom_range(0, 31));
            endcase
            step(($urandom_range(0, 63) == 0), 1'($urandom), la,
                 1'($urandom), ui, 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
